// File: rtl/chaser_pkg.sv
// Shared constants for the LED chaser control stage: key indices, speed range, reset defaults.
// Pure constants, no logic.
package chaser_pkg;
    localparam int KEY_RUN = 0;
    localparam int KEY_DIR = 1;
    localparam int KEY_UP  = 2;
    localparam int KEY_DN  = 3;

    localparam int SPEED_W = 2;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 2'd3;

    localparam logic RUN_RST = 1'b1;
    localparam logic DIR_RST = 1'b0;
endpackage

// File: rtl/chaser_ctrl_key_debounce.sv
// One push key: 2-flop synchronizer, then DEBOUNCE_CYCLES-stable filter; press pulses
// one cycle on an accepted 1->0 change, DEBOUNCE_CYCLES+2 edges after the raw change.
module key_debounce
    import chaser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic nrst,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              stable_q, stable_d;
    logic              press_q, press_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        dcnt_d   = '0;
        press_d  = 1'b0;
        // Any sample matching the stable value drops dcnt back to zero.
        if (sync2_q != stable_q) begin
            if (dcnt_q == DCNT_MAX) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            dcnt_q   <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            press_q  <= press_d;
        end
    end

    assign level = ~stable_q;
    assign press = press_q;
endmodule

// File: rtl/chaser_ctrl.sv
// Key-driven run/dir/speed control plus step_tick clock-enable for the 4-LED chaser.
// Controls update one edge after key_press; step_tick fires every STEP_BASE>>speed cycles while run.
module chaser_ctrl
    import chaser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_BASE       = 1250000
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [3:0]         key_n,
    output logic [3:0]         key_press,
    output logic               run,
    output logic               dir,
    output logic [SPEED_W-1:0] speed,
    output logic               step_tick
);
    localparam int TCNT_W = $clog2(STEP_BASE);

    logic [3:0]         key_level;
    logic [3:0]         key_pulse;
    logic               run_q, run_d;
    logic               dir_q, dir_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               tick_q, tick_d;
    logic [31:0]        period_m1;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk   (clk),
            .nrst  (nrst),
            .key_n (key_n[i]),
            .level (key_level[i]),
            .press (key_pulse[i])
        );
    end

    // A pulse always coincides with the key being held; the AND just makes that explicit.
    assign key_press = key_pulse & key_level;

    always_comb begin
        run_d   = run_q ^ key_press[KEY_RUN];
        dir_d   = dir_q ^ key_press[KEY_DIR];
        speed_d = speed_q;
        if (key_press[KEY_UP] && !key_press[KEY_DN] && speed_q != SPEED_MAX) begin
            speed_d = speed_q + 1'b1;
        end else if (key_press[KEY_DN] && !key_press[KEY_UP] && speed_q != '0) begin
            speed_d = speed_q - 1'b1;
        end

        period_m1 = (32'(STEP_BASE) >> speed_q) - 32'd1;
        tcnt_d    = '0;
        tick_d    = 1'b0;
        // A speed change restarts the period from zero without ticking.
        if (run_q && speed_d == speed_q) begin
            if (32'(tcnt_q) == period_m1) begin
                tick_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_q   <= RUN_RST;
            dir_q   <= DIR_RST;
            speed_q <= '0;
            tcnt_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            tcnt_q  <= tcnt_d;
            tick_q  <= tick_d;
        end
    end

    assign run       = run_q;
    assign dir       = dir_q;
    assign speed     = speed_q;
    assign step_tick = tick_q;
endmodule

// File: tb/tb_chaser_ctrl.sv
// Randomized and directed bench for chaser_ctrl with an event-time reference model and scoreboard.
module tb_chaser_ctrl;
    localparam int D    = 4;
    localparam int BASE = 16;

    logic       clk  = 1'b0;
    logic       nrst = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_press;
    logic       run, dir, step_tick;
    logic [1:0] speed;

    always #5 clk = ~clk;

    chaser_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_BASE(BASE)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .key_n     (key_n),
        .key_press (key_press),
        .run       (run),
        .dir       (dir),
        .speed     (speed),
        .step_tick (step_tick)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } press_ev_t;

    press_ev_t  press_exp[$];
    int         tick_exp[$];

    logic       run_m;
    logic       dir_m;
    int         spd_m;
    int         next_tick;
    logic [3:0] stable_m;
    logic [3:0] pend_m;
    logic [3:0] hist[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: a key is accepted when the D synchronized samples preceding an edge all
    // oppose the accepted level; ticks are predicted as absolute cycle numbers.
    task automatic model_step();
        int         spd_n;
        logic [3:0] newp;
        bit         flip;
        cyc++;
        spd_n = spd_m;
        if (pend_m[2] && !pend_m[3]) spd_n = (spd_m == 3) ? 3 : spd_m + 1;
        if (pend_m[3] && !pend_m[2]) spd_n = (spd_m == 0) ? 0 : spd_m - 1;
        if (run_m && spd_n == spd_m && cyc == next_tick) begin
            tick_exp.push_back(cyc);
            next_tick = cyc + (BASE >> spd_m);
        end
        if (!run_m || spd_n != spd_m) next_tick = cyc + (BASE >> spd_n);
        run_m = run_m ^ pend_m[0];
        dir_m = dir_m ^ pend_m[1];
        spd_m = spd_n;

        newp = 4'h0;
        for (int k = 0; k < 4; k++) begin
            flip = 1'b1;
            for (int j = 1; j <= D; j++)
                if (hist[hist.size() - 1 - j][k] == stable_m[k]) flip = 1'b0;
            if (flip) begin
                stable_m[k] = ~stable_m[k];
                if (!stable_m[k]) newp[k] = 1'b1;
            end
        end
        if (newp != 4'h0) press_exp.push_back('{cyc, newp});
        pend_m = newp;
        hist.push_back(key_n);
        void'(hist.pop_front());
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cyc       = 0;
            run_m     = 1'b1;
            dir_m     = 1'b0;
            spd_m     = 0;
            next_tick = BASE;
            stable_m  = 4'hF;
            pend_m    = 4'h0;
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back(4'hF);
            press_exp.delete();
            tick_exp.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: compares whenever the DUT pulses or the scoreboard expects a pulse now.
    always @(negedge clk) begin
        if (nrst) begin
            logic [3:0] exp_mask;
            bit         exp_tick;
            check("control_state", int'({run, dir, speed}), int'({run_m, dir_m, spd_m[1:0]}));
            exp_mask = (press_exp.size() > 0 && press_exp[0].cyc == cyc) ? press_exp[0].mask : 4'h0;
            if (key_press != 4'h0 || exp_mask != 4'h0) begin
                check("key_press", int'(key_press), int'(exp_mask));
                if (exp_mask != 4'h0) void'(press_exp.pop_front());
            end
            exp_tick = (tick_exp.size() > 0 && tick_exp[0] == cyc);
            if (step_tick || exp_tick) begin
                check("step_tick", int'(step_tick), int'(exp_tick));
                if (exp_tick) void'(tick_exp.pop_front());
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] mask, input int bounces);
        for (int b = 0; b < bounces; b++) begin
            key_n = key_n ^ mask;
            wait_cycles($urandom_range(1, 2));
        end
        key_n = key_n & ~mask;
        wait_cycles(D + 6);
        key_n = key_n | mask;
        wait_cycles(12);
    endtask

    initial begin
        int exp_spd;
        #12;
        check("reset_outputs", int'({key_press, run, dir, speed, step_tick}),
              int'({4'h0, 1'b1, 1'b0, 2'd0, 1'b0}));
        @(negedge clk);
        nrst = 1'b1;
        wait_cycles(50);

        // Bouncing direction key, settling low.
        for (int i = 0; i < 5; i++) begin
            key_n[1] = (i % 2 == 1);
            wait_cycles(2);
        end
        wait_cycles(48);
        check("dir_after_bounce", int'(dir), 1);
        key_n[1] = 1'b1;
        wait_cycles(20);

        exp_spd = 0;
        for (int i = 0; i < 5; i++) begin
            press_key(4'b0100, $urandom_range(0, 2) * 2);
            exp_spd = (exp_spd == 3) ? 3 : exp_spd + 1;
            check("speed_up", int'(speed), exp_spd);
            wait_cycles(20);
        end
        for (int i = 0; i < 4; i++) begin
            press_key(4'b1000, $urandom_range(0, 2) * 2);
            exp_spd = (exp_spd == 0) ? 0 : exp_spd - 1;
            check("speed_down", int'(speed), exp_spd);
            wait_cycles(10);
        end
        wait_cycles(40);

        press_key(4'b0001, 2);
        check("run_paused", int'(run), 0);
        wait_cycles(200);
        press_key(4'b0001, 0);
        check("run_resumed", int'(run), 1);
        wait_cycles(40);

        press_key(4'b0100, 0);
        press_key(4'b1100, 0);
        check("speed_up_dn_same", int'(speed), 1);
        wait_cycles(20);
        press_key(4'b1000, 0);
        check("speed_back_to_0", int'(speed), 0);
        wait_cycles(10);

        // Reset between edges, mid-debounce and mid-period.
        key_n[2] = 1'b0;
        wait_cycles(3);
        #2;
        nrst = 1'b0;
        #1;
        check("midrun_reset_outputs", int'({key_press, run, dir, speed, step_tick}),
              int'({4'h0, 1'b1, 1'b0, 2'd0, 1'b0}));
        key_n = 4'hF;
        wait_cycles(2);
        nrst = 1'b1;
        wait_cycles(40);

        repeat (150) begin
            key_n = 4'($urandom_range(0, 15));
            wait_cycles($urandom_range(1, 9));
        end
        key_n = 4'hF;
        wait_cycles(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
